hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Parametrised hazard/forwarding controller for the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB). Sits beside the ID stage.
- Compares up to NUM_SRC ID-stage source registers against the EXE and MEM destinations and generates:
  - registered forwarding selects, aligned to the EXE stage;
  - load-use stalls lasting LOAD_BUBBLES cycles (FSM-timed);
  - branch flushes;
  - a whole-pipe freeze while data memory is not ready.

Parameters:
- REG_AW, 4, register address width.
- NUM_SRC, 3, number of ID source operands (Rn, Rm, Rs).
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard; range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_src  in  NUM_SRC*REG_AW  ID source registers; operand i is at [i*REG_AW +: REG_AW].
- id_src_vld  in  NUM_SRC  per-operand "register is read"; generalises two_src.
- exe_dest  in  REG_AW  destination register of the instruction in EXE.
- exe_wb_en  in  1  instruction in EXE writes exe_dest.
- exe_mem_rd  in  1  instruction in EXE is a load (LDR).
- mem_dest  in  REG_AW  destination register of the instruction in MEM.
- mem_wb_en  in  1  instruction in MEM writes mem_dest.
- branch_taken  in  1  taken branch resolved in EXE.
- mem_ready  in  1  data memory has completed its access.
- freeze  out  1  every pipeline register and the PC hold.
- stall  out  1  PC and IF/ID hold; a bubble enters ID/EXE.
- flush  out  1  IF/ID and ID/EXE are cleared.
- fwd_sel  out  NUM_SRC*2  per operand, registered: 0 = register file, 1 = MEM-stage result, 2 = WB-stage result.
- hazard  out  1  equals stall; kept for existing pipeline wiring.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, cnt=0, fwd_sel=0.
  - freeze, stall, flush and hazard are forced to 0 while rst=0.
- Operand match: operand i matches stage X when id_src_vld[i] & X_wb_en & (id_src[i]==X_dest).
- Outputs, in priority order:
  1. freeze = ~mem_ready. When freeze=1:
     - stall=0 and flush=0;
     - FSM, cnt and fwd_sel all hold.
  2. flush = mem_ready & branch_taken.
     - Flush overrides stall: the ID instruction is on the wrong path.
     - FSM is forced to RUN and cnt cleared.
     - fwd_sel is loaded with 0.
  3. stall, combinational:
     - in RUN: stall = load_use, where load_use = exe_mem_rd & (any operand matches EXE);
     - in LSTALL: stall = 1.
- FSM:
  - RUN --load_use & LOAD_BUBBLES>1--> LSTALL, with cnt=LOAD_BUBBLES-1.
  - LSTALL: each non-frozen cycle, cnt decrements; when cnt==1, next state is RUN.
  - flush in any state forces RUN.
- fwd_sel update, on non-frozen, non-flush cycles:
  - If stall=1: fwd_sel is loaded with 0, because a bubble enters EXE.
  - Otherwise, per operand: EXE match → 1; else MEM match → 2; else 0. EXE has priority: it is the younger producer.
  - Result is registered, so it is valid in the cycle the instruction occupies EXE.
- Register 15 (PC) as a destination is treated like any other register; no special case.
- Single-bubble load-use timing:
  - Cycle N: load in EXE, consumer in ID → stall=1.
  - Cycle N+1: load in MEM, match on MEM → fwd_sel=2 registered.
  - Cycle N+2: consumer in EXE takes the WB-stage result.

Optional Feature:
- Macro: HCU_FORWARDING_EN.
- Defined: behaviour exactly as above.
- Undefined (non-forwarding mode):
  - fwd_sel is tied to 0;
  - stall = any operand matching EXE or MEM (regardless of exe_mem_rd), recomputed every cycle;
  - the FSM stays in RUN;
  - freeze and flush priority are unchanged.

Decomposition:
- Shared package hcu_pkg holds:
  - FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2;
  - FSM state encoding (RUN, LSTALL);
  - default REG_AW.
- One natural sub-module, hcu_src_cmp: per-operand comparator producing match_exe and match_mem. It is instantiated NUM_SRC times in a generate loop.

Test Plan:
1. Forwarding path, distance 1 (HCU_FORWARDING_EN defined):
   - Stimulus: exe_dest=3, exe_wb_en=1, exe_mem_rd=0, id_src[0]=3, id_src_vld=3'b001.
   - Response: stall=0; next cycle fwd_sel[1:0]=1.
2. Forwarding path, distance 2:
   - Stimulus: mem_dest=5, mem_wb_en=1, id_src[1]=5.
   - Response: next cycle fwd_sel[3:2]=2.
3. Load-use with LOAD_BUBBLES=3:
   - Stimulus: exe_mem_rd=1, exe_dest=2, id_src[0]=2.
   - Response: stall=1 for exactly 3 cycles; fwd_sel=0 during those cycles; FSM then returns to RUN.
4. Branch during LSTALL:
   - Stimulus: branch_taken=1 in cycle 2 of the stall.
   - Response: flush=1, stall=0; RUN on the next cycle.
5. Memory wait in the middle of a load-use stall:
   - Stimulus: mem_ready=0 for 4 cycles.
   - Response: freeze=1; cnt and fwd_sel unchanged; the stall resumes with the same remaining count.
6. Reset mid-LSTALL:
   - Stimulus: rst=0 asynchronously.
   - Response: all outputs 0 immediately; state RUN after release.
7. Non-forwarding build (HCU_FORWARDING_EN undefined):
   - Stimulus: mem match only.
   - Response: stall=1 and fwd_sel=0.

Source files
------------

// File: rtl/hcu_pkg.sv
// Shared constants for the hazard control unit: forwarding selects, FSM states, default widths.
package hcu_pkg;

   localparam int unsigned REG_AW_DEF = 4;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   localparam logic [0:0] StRun    = 1'b0;
   localparam logic [0:0] StLstall = 1'b1;

endpackage

// File: rtl/hcu_src_cmp.sv
// Per-operand comparator: does this ID source register match the EXE or MEM destination?
module hcu_src_cmp
   import hcu_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] src,
   input  logic              src_vld,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              exe_wb_en,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wb_en,
   output logic              match_exe,
   output logic              match_mem
);

   assign match_exe = src_vld & exe_wb_en & (src == exe_dest);
   assign match_mem = src_vld & mem_wb_en & (src == mem_dest);

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline, placed beside ID.
// Define HCU_FORWARDING_EN for forwarding with FSM-timed load-use stalls; otherwise stall on any match.
module hazard_control_unit
   import hcu_pkg::*;
#(
   parameter int unsigned REG_AW       = REG_AW_DEF,
   parameter int unsigned NUM_SRC      = 3,
   parameter int unsigned LOAD_BUBBLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_vld,
   input  logic [REG_AW-1:0]         exe_dest,
   input  logic                      exe_wb_en,
   input  logic                      exe_mem_rd,
   input  logic [REG_AW-1:0]         mem_dest,
   input  logic                      mem_wb_en,
   input  logic                      branch_taken,
   input  logic                      mem_ready,
   output logic                      freeze,
   output logic                      stall,
   output logic                      flush,
   output logic [NUM_SRC*2-1:0]      fwd_sel,
   output logic                      hazard
);

   logic [NUM_SRC-1:0]   match_exe;
   logic [NUM_SRC-1:0]   match_mem;
   logic [0:0]           state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [NUM_SRC*2-1:0] fwd_q, fwd_d;
   logic                 freeze_raw, flush_raw, stall_raw;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
      hcu_src_cmp #(
         .REG_AW (REG_AW)
      ) u_cmp (
         .src       (id_src[i*REG_AW +: REG_AW]),
         .src_vld   (id_src_vld[i]),
         .exe_dest  (exe_dest),
         .exe_wb_en (exe_wb_en),
         .mem_dest  (mem_dest),
         .mem_wb_en (mem_wb_en),
         .match_exe (match_exe[i]),
         .match_mem (match_mem[i])
      );
   end

   assign freeze_raw = ~mem_ready;
   assign flush_raw  = mem_ready & branch_taken;

`ifdef HCU_FORWARDING_EN
   logic load_use;
   assign load_use  = exe_mem_rd & (|match_exe);
   // Flush wins over stall: the instruction in ID is on the wrong path.
   assign stall_raw = mem_ready & ~branch_taken & ((state_q == StLstall) | load_use);
`else
   logic unused_nofwd;
   assign unused_nofwd = exe_mem_rd ^ (LOAD_BUBBLES > 1);
   assign stall_raw    = mem_ready & ~branch_taken & ((|match_exe) | (|match_mem));
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fwd_d   = fwd_q;
      if (freeze_raw) begin
         // Whole pipe holds while data memory is busy.
      end else if (flush_raw) begin
         state_d = StRun;
         cnt_d   = '0;
         fwd_d   = '0;
      end else begin
`ifdef HCU_FORWARDING_EN
         if (state_q == StRun) begin
            if (load_use && (LOAD_BUBBLES > 1)) begin
               state_d = StLstall;
               cnt_d   = 3'(LOAD_BUBBLES - 1);
            end
         end else begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = StRun;
            end
         end
         if (stall_raw) begin
            fwd_d = '0;
         end else begin
            // EXE is the younger producer, so it beats MEM.
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
               if (match_exe[i]) begin
                  fwd_d[2*i +: 2] = FWD_MEM;
               end else if (match_mem[i]) begin
                  fwd_d[2*i +: 2] = FWD_WB;
               end else begin
                  fwd_d[2*i +: 2] = FWD_RF;
               end
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
         fwd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fwd_q   <= fwd_d;
      end
   end

   assign freeze  = rst & freeze_raw;
   assign flush   = rst & flush_raw;
   assign stall   = rst & stall_raw;
   assign hazard  = stall;
   assign fwd_sel = fwd_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table, directed stall/flush/freeze/reset
// sequences and randomized traffic against a bubble-counting reference model.
module tb_hazard_control_unit;

`ifdef HCU_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int LB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] id_src = '0;
   logic [2:0]  id_src_vld = '0;
   logic [3:0]  exe_dest = '0;
   logic        exe_wb_en = 1'b0;
   logic        exe_mem_rd = 1'b0;
   logic [3:0]  mem_dest = '0;
   logic        mem_wb_en = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_ready = 1'b1;
   logic        freeze, stall, flush, hazard;
   logic [5:0]  fwd_sel;

   int checks = 0;
   int errors = 0;

   hazard_control_unit #(
      .REG_AW       (4),
      .NUM_SRC      (3),
      .LOAD_BUBBLES (LB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_src       (id_src),
      .id_src_vld   (id_src_vld),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_rd   (exe_mem_rd),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .freeze       (freeze),
      .stall        (stall),
      .flush        (flush),
      .fwd_sel      (fwd_sel),
      .hazard       (hazard)
   );

   always #5 clk = ~clk;

   // Reference model: remaining forced bubbles and the registered select value.
   int         m_left = 0;
   logic [5:0] m_fwd = '0;
   int         n_left;
   logic [5:0] n_fwd;
   logic       e_freeze, e_flush, e_stall;
   logic       s_freeze, s_flush, s_stall;
   logic [5:0] s_fwd;

   typedef struct {
      string       nm;
      logic [11:0] src;
      logic [2:0]  vld;
      logic [3:0]  ed;
      logic        ew;
      logic        er;
      logic [3:0]  md;
      logic        mw;
      logic        br;
      logic        rdy;
      logic        x_freeze;
      logic        x_flush;
      logic        x_stall_f;
      logic        x_stall_n;
      logic [5:0]  x_fwd_f;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [11:0] s, input logic [2:0] v, input logic [3:0] ed,
                        input logic ew, input logic er, input logic [3:0] md, input logic mw,
                        input logic br, input logic rdy);
      id_src = s; id_src_vld = v; exe_dest = ed; exe_wb_en = ew; exe_mem_rd = er;
      mem_dest = md; mem_wb_en = mw; branch_taken = br; mem_ready = rdy;
   endtask

   task automatic drive_idle();
      drive(12'h000, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic model_eval();
      int   sel[3];
      logic me, mm, any_e, any_m, lu;
      logic [3:0] s;
      any_e = 1'b0;
      any_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s = id_src[i*4 +: 4];
         me = id_src_vld[i] && exe_wb_en && (s == exe_dest);
         mm = id_src_vld[i] && mem_wb_en && (s == mem_dest);
         any_e |= me;
         any_m |= mm;
         sel[i] = me ? 1 : (mm ? 2 : 0);
      end
      lu = FWD && exe_mem_rd && any_e;
      e_freeze = !mem_ready;
      e_flush  = mem_ready && branch_taken;
      if (FWD) e_stall = mem_ready && !branch_taken && (m_left > 0 || lu);
      else     e_stall = mem_ready && !branch_taken && (any_e || any_m);
      n_left = m_left;
      n_fwd  = m_fwd;
      if (!mem_ready) begin
         n_left = m_left;
      end else if (branch_taken) begin
         n_left = 0;
         n_fwd  = '0;
      end else begin
         if (m_left > 0) n_left = m_left - 1;
         else if (lu)    n_left = LB - 1;
         n_fwd = '0;
         if (FWD && !e_stall)
            for (int i = 0; i < 3; i++) n_fwd[i*2 +: 2] = 2'(sel[i]);
      end
   endtask

   task automatic run_cycle(input string tag);
      @(negedge clk);
      model_eval();
      s_freeze = freeze; s_flush = flush; s_stall = stall; s_fwd = fwd_sel;
      chk({tag, " freeze"}, {5'd0, freeze}, {5'd0, e_freeze});
      chk({tag, " flush"}, {5'd0, flush}, {5'd0, e_flush});
      chk({tag, " stall"}, {5'd0, stall}, {5'd0, e_stall});
      chk({tag, " hazard"}, {5'd0, hazard}, {5'd0, e_stall});
      chk({tag, " fwd_sel"}, fwd_sel, m_fwd);
      @(posedge clk);
      m_left = n_left;
      m_fwd  = n_fwd;
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cnt_stall, cnt_freeze;
      tv[0]  = '{"fwd_d1",   12'h003, 3'b001, 4'd3, 1, 0, 4'd0, 0, 0, 1, 0, 0, 0, 1, 6'b000001};
      tv[1]  = '{"fwd_d2",   12'h050, 3'b010, 4'd0, 0, 0, 4'd5, 1, 0, 1, 0, 0, 0, 1, 6'b001000};
      tv[2]  = '{"exe_prio", 12'h700, 3'b100, 4'd7, 1, 0, 4'd7, 1, 0, 1, 0, 0, 0, 1, 6'b010000};
      tv[3]  = '{"load_use", 12'h002, 3'b001, 4'd2, 1, 1, 4'd0, 0, 0, 1, 0, 0, 1, 1, 6'b000000};
      tv[4]  = '{"no_vld",   12'h002, 3'b000, 4'd2, 1, 1, 4'd2, 1, 0, 1, 0, 0, 0, 0, 6'b000000};
      tv[5]  = '{"no_wb",    12'h004, 3'b001, 4'd4, 0, 1, 4'd4, 0, 0, 1, 0, 0, 0, 0, 6'b000000};
      tv[6]  = '{"br_lu",    12'h002, 3'b001, 4'd2, 1, 1, 4'd0, 0, 1, 1, 0, 1, 0, 0, 6'b000000};
      tv[7]  = '{"freeze",   12'h002, 3'b001, 4'd2, 1, 1, 4'd0, 0, 1, 0, 1, 0, 0, 0, 6'b000000};
      tv[8]  = '{"r15",      12'h0FF, 3'b011, 4'd15, 1, 0, 4'd15, 1, 0, 1, 0, 0, 0, 1, 6'b000101};
      tv[9]  = '{"mixed",    12'h921, 3'b111, 4'd2, 1, 0, 4'd1, 1, 0, 1, 0, 0, 0, 1, 6'b000110};
      tv[10] = '{"lu_op2",   12'h608, 3'b101, 4'd6, 1, 1, 4'd8, 1, 0, 1, 0, 0, 1, 1, 6'b000000};
      tv[11] = '{"ld_nomat", 12'h321, 3'b111, 4'd6, 1, 1, 4'd0, 0, 0, 1, 0, 0, 0, 0, 6'b000000};

      // Outputs forced low while in reset, even with memory busy and a branch pending.
      drive(12'h002, 3'b001, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst freeze", {5'd0, freeze}, 6'd0);
      branch_taken = 1'b1; mem_ready = 1'b1;
      #1;
      chk("rst flush", {5'd0, flush}, 6'd0);
      branch_taken = 1'b0;
      #1;
      chk("rst stall", {5'd0, stall}, 6'd0);
      chk("rst fwd_sel", fwd_sel, 6'd0);
      drive_idle();
      @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: check the vector cycle, then the registered select one cycle later.
      foreach (tv[k]) begin
         drive(tv[k].src, tv[k].vld, tv[k].ed, tv[k].ew, tv[k].er, tv[k].md, tv[k].mw,
               tv[k].br, tv[k].rdy);
         run_cycle(tv[k].nm);
         chk({tv[k].nm, " tbl freeze"}, {5'd0, s_freeze}, {5'd0, tv[k].x_freeze});
         chk({tv[k].nm, " tbl flush"}, {5'd0, s_flush}, {5'd0, tv[k].x_flush});
         chk({tv[k].nm, " tbl stall"}, {5'd0, s_stall},
             {5'd0, FWD ? tv[k].x_stall_f : tv[k].x_stall_n});
         drive_idle();
         run_cycle({tv[k].nm, "+1"});
         chk({tv[k].nm, " tbl fwd_sel"}, s_fwd, FWD ? tv[k].x_fwd_f : 6'd0);
         drive(12'h000, 3'b000, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
         run_cycle({tv[k].nm, " flush"});
      end

      // Load-use: stall lasts LOAD_BUBBLES cycles in forwarding mode.
      cnt_stall = 0;
      drive(12'h002, 3'b001, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      run_cycle("lu3 c0");
      cnt_stall += int'(s_stall);
      drive(12'h002, 3'b001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      for (int c = 1; c < 6; c++) begin
         run_cycle("lu3");
         cnt_stall += int'(s_stall);
      end
      chk("lu3 stall count", 6'(cnt_stall), FWD ? 6'd3 : 6'd1);

      // Branch in the second stall cycle flushes and returns to RUN.
      drive(12'h002, 3'b001, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      run_cycle("br c0");
      drive(12'h002, 3'b001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      run_cycle("br c1");
      chk("br flush", {5'd0, s_flush}, 6'd1);
      chk("br stall", {5'd0, s_stall}, 6'd0);
      branch_taken = 1'b0;
      run_cycle("br c2");
      chk("br run stall", {5'd0, s_stall}, 6'd0);

      // Memory wait mid-stall: freeze holds the remaining count.
      cnt_stall = 0;
      cnt_freeze = 0;
      drive(12'h002, 3'b001, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      run_cycle("mw c0");
      cnt_stall += int'(s_stall);
      drive(12'h002, 3'b001, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         run_cycle("mw frz");
         cnt_freeze += int'(s_freeze);
         cnt_stall += int'(s_stall);
      end
      mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         run_cycle("mw run");
         cnt_stall += int'(s_stall);
      end
      chk("mw freeze count", 6'(cnt_freeze), 6'd4);
      chk("mw stall count", 6'(cnt_stall), FWD ? 6'd3 : 6'd1);

      // Asynchronous reset in the middle of a stall.
      drive(12'h002, 3'b001, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      run_cycle("ar c0");
      run_cycle("ar c1");
      #2 rst = 1'b0;
      #1;
      chk("ar stall", {5'd0, stall}, 6'd0);
      chk("ar hazard", {5'd0, hazard}, 6'd0);
      chk("ar fwd_sel", fwd_sel, 6'd0);
      mem_ready = 1'b0;
      #1;
      chk("ar freeze", {5'd0, freeze}, 6'd0);
      mem_ready = 1'b1; branch_taken = 1'b1;
      #1;
      chk("ar flush", {5'd0, flush}, 6'd0);
      drive_idle();
      m_left = 0;
      m_fwd  = '0;
      @(negedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      run_cycle("ar run");
      chk("ar run stall", {5'd0, s_stall}, 6'd0);

      // Randomized traffic on a small register range to provoke matches.
      for (int c = 0; c < 400; c++) begin
         drive({4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
               3'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
               4'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 7) != 0));
         run_cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
